program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
- 16-bit program counter register for the general-purpose processor's fetch path.
- Holds the address of the next instruction.
- Supports a parallel load for jumps, branches and calls, and a +1 increment for sequential fetch.
- Output drives the instruction-address path; the control unit issues `ld` and `inc`.

Parameters:
- WIDTH, 16, bit width of the counter and of the `in`/`out` buses.
- RESET_VALUE, 16'h0000, value forced onto `out` while reset is asserted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_b  input  1  reset, asynchronous, active-low; forces `out` to RESET_VALUE.
- ld  input  1  synchronous load enable; captures `in` at the next rising edge.
- inc  input  1  synchronous increment enable; `out` <= `out` + 1 at the next rising edge.
- in  input  WIDTH  parallel load value (branch/jump target).
- out  output  WIDTH  current PC value; registered, never combinational from inputs.

Behaviour:
- Interface: one clock, `clk`. Reset is asynchronous and active-low, on `rst_b`.
- Reset:
  - `rst_b` = 0 forces `out` = RESET_VALUE (0x0000) immediately, independent of `clk`.
  - Held while low. Overrides `ld` and `inc`.
- Reset mid-operation:
  - Asserting `rst_b` during a load or increment sequence clears `out` at once.
  - After `rst_b` rises, the first rising edge evaluates `ld`/`inc` normally.
- On each rising `clk` edge with `rst_b` = 1, priority order is:
  - `ld` = 1: `out` <= `in`. Load wins; `inc` is ignored when both are high.
  - `ld` = 0, `inc` = 1: `out` <= (`out` + 1) mod 2^WIDTH.
  - `ld` = 0, `inc` = 0: `out` holds its value.
- Latency: one clock. A new value is visible on `out` right after the capturing edge and stable for the whole following cycle.
- Arithmetic:
  - Unsigned, WIDTH bits. Increment wraps 0xFFFF -> 0x0000.
  - No carry-out or overflow flag.
- Continuous increment: with `inc` held high, `out` advances by exactly 1 per clock edge.
- `in` is sampled only at a rising edge with `ld` = 1. Changes to `in` at other times have no effect.
- No X propagation from `in` when `ld` = 0.
- Flops are positive-edge triggered with asynchronous clear.
- No other state exists in the block.

Test Plan:
- Reset: `rst_b` = 0 with `ld` = `inc` = 0, then release and wait one edge -> `out` = 0x0000.
- Load then increment:
  - `in` = 0x1234, `ld` = 1 for one edge -> `out` = 0x1234.
  - Then `ld` = 0, `inc` = 1 for three edges -> 0x1235, 0x1236, 0x1237.
  - Then `inc` = 0 for two edges -> `out` stays 0x1237.
- Priority: `in` = 0xABCD with `ld` = 1 and `inc` = 1 on the same edge -> `out` = 0xABCD, not 0x1238 or 0xABCE.
- Wrap-around: load 0xFFFF, then one `inc` edge -> `out` = 0x0000.
- Zero increment: load 0x0000, then one `inc` edge -> `out` = 0x0001.
- Async reset mid-count:
  - With `inc` = 1 at `out` = 0x0005, drop `rst_b` between clock edges -> `out` = 0x0000 immediately, without waiting for a clock edge.
  - Release `rst_b` -> next edge gives 0x0001.

Source files
------------

// File: rtl/program_counter.sv
// Program counter for the fetch path.
// Holds the address of the next instruction. The control unit can either
// load a jump/branch/call target from `in`, or advance the count by one for
// sequential fetch. Load has priority over increment. The count is unsigned
// and wraps from all-ones back to zero. `out` comes straight from the
// register, so it never depends combinationally on any input.
// Reset is asynchronous and active-low: `rst_b` low forces RESET_VALUE onto
// `out` at once, without waiting for a clock edge.
module program_counter #(
  parameter int unsigned          WIDTH       = 16,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             ld,
  input  logic             inc,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  // Current PC value and its next-state value.
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // Sequential successor of the current PC. The carry out of the top bit is
  // dropped on purpose, so all-ones wraps to zero.
  logic [WIDTH-1:0] pc_plus_one;
  assign pc_plus_one = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};

  // Next-state selection: load wins over increment, otherwise hold.
  // `in` only reaches pc_d when ld is high. An unknown `in` therefore cannot
  // leak into the PC while no load is requested.
  always_comb begin
    pc_d = pc_q;
    if (ld) begin
      pc_d = in;
    end else if (inc) begin
      pc_d = pc_plus_one;
    end
  end

  // PC register with asynchronous active-low clear to RESET_VALUE.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pc_q <= RESET_VALUE;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign out = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter.
// The model keeps the architectural PC as a plain integer. Each driven cycle
// predicts the next PC from the rules: load, else +1 mod 2^16, else hold.
// A compare process checks `out` on every falling edge.
// The scenario runs the directed test plan first, then randomized traffic
// with occasional asynchronous reset pulses.
module tb_program_counter;

  localparam int unsigned W      = 16;
  localparam logic [W-1:0] RST_V = 16'h0000;

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         rst_b;
  logic         ld;
  logic         inc;
  logic [W-1:0] in_bus;
  logic [W-1:0] out_bus;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  program_counter #(
    .WIDTH       (W),
    .RESET_VALUE (RST_V)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .ld    (ld),
    .inc   (inc),
    .in    (in_bus),
    .out   (out_bus)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int unsigned  model_pc;
  int           n_checks;
  int           n_errors;
  bit           sim_done;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Checks the model itself against a hand-computed value, and also checks
  // the DUT output against that value.
  task automatic check_lit(input string name, input logic [W-1:0] want);
    check({name, "_dut"}, out_bus, want);
    check({name, "_model"}, model_pc[W-1:0], want);
  endtask

  // ---------------- compare process ----------------
  // Checks on every falling edge. While reset is held, `out` must be
  // RESET_VALUE. Otherwise `out` is checked against the prediction for the
  // last capturing edge.
  initial begin
    logic [W-1:0] e;
    while (!sim_done) begin
      @(negedge clk);
      if (!rst_b) begin
        check("reset_hold", out_bus, RST_V);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("model", out_bus, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drives one cycle's controls at the falling edge and predicts the PC after
  // the next rising edge. The prediction is queued just after that edge.
  task automatic step(input logic l, input logic i, input logic [W-1:0] d);
    int unsigned nxt;
    @(negedge clk);
    ld     = l;
    inc    = i;
    in_bus = d;
    if (l)      nxt = d;
    else if (i) nxt = (model_pc + 1) % (1 << W);
    else        nxt = model_pc;
    @(posedge clk);
    #1;
    model_pc = nxt;
    exp_q.push_back(nxt[W-1:0]);
  endtask

  // Pulses reset between clock edges. The clear must be visible at once,
  // with no clock edge in between. Reset stays low across one rising edge.
  task automatic async_reset_pulse(input string name);
    @(negedge clk);
    #2;
    rst_b = 1'b0;
    model_pc = 0;
    #1;
    check({name, "_async_clear"}, out_bus, RST_V);
    @(posedge clk);
    #2;
    rst_b = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    sim_done = 1'b0;
    model_pc = 0;
    rst_b    = 1'b0;
    ld       = 1'b0;
    inc      = 1'b0;
    in_bus   = '0;

    // Reset held for a couple of edges, then released away from the edge.
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_b = 1'b1;
    step(1'b0, 1'b0, 16'h0000);
    check_lit("after_reset", 16'h0000);

    // Load, then three increments, then hold for two edges.
    step(1'b1, 1'b0, 16'h1234);
    check_lit("load_1234", 16'h1234);
    step(1'b0, 1'b1, 16'h0000);
    check_lit("inc_1", 16'h1235);
    step(1'b0, 1'b1, 16'h0000);
    check_lit("inc_2", 16'h1236);
    step(1'b0, 1'b1, 16'h0000);
    check_lit("inc_3", 16'h1237);
    step(1'b0, 1'b0, 16'h5555);
    step(1'b0, 1'b0, 16'hAAAA);
    check_lit("hold_2", 16'h1237);

    // Load wins over increment.
    step(1'b1, 1'b1, 16'hABCD);
    check_lit("ld_priority", 16'hABCD);

    // Wrap-around, then increment from zero.
    step(1'b1, 1'b0, 16'hFFFF);
    step(1'b0, 1'b1, 16'h0000);
    check_lit("wrap", 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h0000);
    check_lit("zero_inc", 16'h0001);

    // An unknown `in` must not matter while ld is low.
    step(1'b0, 1'b1, 'x);
    step(1'b0, 1'b0, 'x);
    check_lit("x_in_ignored", 16'h0002);

    // Asynchronous reset mid-count at 0x0005 with inc held high.
    step(1'b1, 1'b0, 16'h0005);
    check_lit("at_5", 16'h0005);
    @(negedge clk);
    ld  = 1'b0;
    inc = 1'b1;
    #2;
    rst_b = 1'b0;
    model_pc = 0;
    #1;
    check("midcount_async_clear", out_bus, RST_V);
    @(posedge clk);
    #1;
    check("reset_overrides_inc", out_bus, RST_V);
    #1;
    rst_b = 1'b1;
    step(1'b0, 1'b1, 16'h0000);
    check_lit("post_reset_inc", 16'h0001);

    // Randomized traffic with occasional reset pulses.
    for (int k = 0; k < 400; k++) begin
      logic          rl;
      logic          ri;
      logic [W-1:0]  rd;
      int unsigned   pick;
      rl = ($urandom_range(0, 3) == 0);
      ri = ($urandom_range(0, 9) < 6);
      pick = $urandom_range(0, 9);
      if (pick == 0)      rd = 16'hFFFF;
      else if (pick == 1) rd = 16'hFFFE;
      else                rd = W'($urandom);
      if (!rl && $urandom_range(0, 7) == 0) rd = 'x;
      step(rl, ri, rd);
      if ($urandom_range(0, 49) == 0) begin
        async_reset_pulse("rand");
      end
    end

    // Let the compare process drain the last prediction.
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d predictions left unchecked, 0 expected", exp_q.size());
    end
    sim_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
